// File: rtl/state_reg_unit.sv
// State-holding stage of the two-bit Moore machine: input synchronizer, present-state
// register with enable, Moore output and a counter of entries into state 11.
module state_reg_unit #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             x_in,
   input  logic             d1,
   input  logic             d0,
   output logic             q1,
   output logic             q0,
   output logic             x,
   output logic             z,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("state_reg_unit: SYNC_STAGES must be at least 2");
      end
   endgenerate

   // Increment with the carry out exposed so the wrap can set the sticky flag.
   function automatic logic [CNT_W:0] inc_wrap(input logic [CNT_W-1:0] v);
      return {1'b0, v} + {{CNT_W{1'b0}}, 1'b1};
   endfunction

   logic [SYNC_STAGES-1:0] r_sync;
   logic [1:0]             r_q;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_ovf;

   logic [1:0]             w_d;
   logic                   w_entry;
   logic [CNT_W:0]         w_cnt_inc;

   assign w_d       = {d1, d0};
   assign w_entry   = en && (w_d == 2'b11) && (r_q != 2'b11);
   assign w_cnt_inc = inc_wrap(r_cnt);

   // Synchronizer shifts every cycle regardless of en or clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], x_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= 2'b00;
      end else if (en) begin
         r_q <= w_d;
      end
   end

   // clr wins over a simultaneous entry; the entry is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (clr) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_entry) begin
         r_cnt <= w_cnt_inc[CNT_W-1:0];
         if (w_cnt_inc[CNT_W]) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign q1  = r_q[1];
   assign q0  = r_q[0];
   assign x   = r_sync[SYNC_STAGES-1];
   assign z   = r_q[1] & r_q[0];
   assign cnt = r_cnt;
   assign ovf = r_ovf;

endmodule

// File: tb/tb_state_reg_unit.sv
// Directed bench for state_reg_unit: vector table for state/enable/count behaviour plus
// hand-written sequences for reset, synchronizer latency, wrap and asynchronous reset.
module tb_state_reg_unit;

   logic       clk = 1'b0;
   logic       rst_n, en, clr, x_in, d1, d0;
   logic       q1, q0, x, z, ovf;
   logic [7:0] cnt;

   int checks = 0;
   int errors = 0;

   state_reg_unit #(.SYNC_STAGES(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x_in(x_in),
      .d1(d1), .d0(d0), .q1(q1), .q0(q0), .x(x), .z(z), .cnt(cnt), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       clr;
      logic [1:0] d;
      logic [1:0] eq;
      logic       ez;
      logic [7:0] ecnt;
      logic       eovf;
   } vec_t;

   vec_t tbl[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [1:0] eq, input logic ez,
                            input logic [7:0] ecnt, input logic eovf);
      check({tag, ".q"}, {30'd0, q1, q0}, {30'd0, eq});
      check({tag, ".z"}, {31'd0, z}, {31'd0, ez});
      check({tag, ".cnt"}, {24'd0, cnt}, {24'd0, ecnt});
      check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
   endtask

   // One entry: go to 11, then back to 00.
   task automatic entry_pair();
      {d1, d0} = 2'b11; step();
      {d1, d0} = 2'b00; step();
   endtask

   initial begin
      // enable hold, then entry counting 00->11->11->11->01->11, then misc
      tbl[0]  = '{1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 8'd0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 8'd0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 8'd0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 8'd0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 8'd0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 8'd0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 8'd1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 8'd1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 8'd1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 8'd1, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 8'd2, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 8'd2, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 2'b11, 2'b10, 1'b0, 8'd2, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 8'd2, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 8'd0, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 8'd1, 1'b0};
      tbl[16] = '{1'b1, 1'b1, 2'b11, 2'b11, 1'b1, 8'd0, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 8'd0, 1'b0};
      tbl[18] = '{1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 8'd1, 1'b0};

      // Reset held with x_in=1 and d=11
      rst_n = 1'b0; en = 1'b1; clr = 1'b0; x_in = 1'b1; {d1, d0} = 2'b11;
      repeat (3) step();
      check_all("reset", 2'b00, 1'b0, 8'd0, 1'b0);
      check("reset.x", {31'd0, x}, 32'd0);

      // Release, then x_in 0->1 must reach x after exactly 2 edges
      {d1, d0} = 2'b00; x_in = 1'b0;
      rst_n = 1'b1;
      repeat (3) step();
      check("sync.x_low", {31'd0, x}, 32'd0);
      x_in = 1'b1;
      step();
      check("sync.x_edge1", {31'd0, x}, 32'd0);
      step();
      check("sync.x_edge2", {31'd0, x}, 32'd1);
      check_all("sync.state", 2'b00, 1'b0, 8'd0, 1'b0);

      for (int i = 0; i < 19; i++) begin
         en = tbl[i].en; clr = tbl[i].clr; {d1, d0} = tbl[i].d;
         step();
         check_all($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ez, tbl[i].ecnt, tbl[i].eovf);
      end

      // Wrap: clear, then 256 entries
      en = 1'b1; clr = 1'b1; {d1, d0} = 2'b00; step(); clr = 1'b0;
      check_all("wrap.start", 2'b00, 1'b0, 8'd0, 1'b0);
      for (int i = 1; i <= 256; i++) begin
         entry_pair();
         if (i == 1 || i == 128 || i == 255)
            check_all($sformatf("wrap.n%0d", i), 2'b00, 1'b0, 8'(i), 1'b0);
      end
      check_all("wrap.n256", 2'b00, 1'b0, 8'd0, 1'b1);
      {d1, d0} = 2'b11; step();
      check_all("wrap.n257", 2'b11, 1'b1, 8'd1, 1'b1);

      // Clear priority: cnt=5, ovf=1, q=01, then clr with a 01->11 entry
      {d1, d0} = 2'b00; step();
      repeat (4) entry_pair();
      check_all("clrpri.pre5", 2'b00, 1'b0, 8'd5, 1'b1);
      {d1, d0} = 2'b01; step();
      clr = 1'b1; {d1, d0} = 2'b11; step(); clr = 1'b0;
      check_all("clrpri.post", 2'b11, 1'b1, 8'd0, 1'b0);

      // Asynchronous reset mid-cycle with q=11, cnt=7
      {d1, d0} = 2'b00; step();
      repeat (6) entry_pair();
      {d1, d0} = 2'b11; step();
      check_all("arst.pre", 2'b11, 1'b1, 8'd7, 1'b0);
      check("arst.pre_x", {31'd0, x}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_all("arst.post", 2'b00, 1'b0, 8'd0, 1'b0);
      check("arst.post_x", {31'd0, x}, 32'd0);
      step();
      check_all("arst.held", 2'b00, 1'b0, 8'd0, 1'b0);
      rst_n = 1'b1;
      step();
      check_all("arst.release", 2'b11, 1'b1, 8'd1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/state_reg_unit.md
# state_reg_unit

State-holding stage of the project's two-bit Moore machine. It sits directly around the combinational next-state generator: it registers next-state bits `d1`/`d0` into `q1`/`q0` and feeds them back. It also synchronizes the raw external input into `x` and produces the Moore output `z`. A counter records how many times the machine has entered state 11.

## Interface
Parameters:
- `SYNC_STAGES`, 2: number of flip-flops in the `x_in` synchronizer chain. Minimum 2.
- `CNT_W`, 8: width of the entry counter `cnt`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock for all state.
- `rst_n` input 1: asynchronous active-low reset.
- `en` input 1: state-update enable. When 0, the state holds.
- `clr` input 1: synchronous clear of `cnt` and `ovf`.
- `x_in` input 1: raw asynchronous machine input.
- `d1`, `d0` input 1 each: next-state bits from the next-state generator.
- `q1`, `q0` output 1 each: registered present state, fed to the next-state generator.
- `x` output 1: synchronized input, fed to the next-state generator.
- `z` output 1: Moore output, `q1 & q0`.
- `cnt` output CNT_W: number of entries into state 11, modulo 2^CNT_W.
- `ovf` output 1: sticky flag, set when `cnt` wraps.

## Operation
- **Synchronizer:** a chain of SYNC_STAGES flip-flops, `x_in` → s[0] → … → s[SYNC_STAGES-1]. `x` is driven by the last stage. The chain shifts every cycle, independent of `en`.
- **State register:** on each rising edge with `en`=1, {`q1`,`q0`} ← {`d1`,`d0`}. With `en`=0, {`q1`,`q0`} holds.
- **Output:** `z` is combinational from the registered state only, so it is glitch-free relative to `x_in`.
- **Entry event:** `en`=1 and {`d1`,`d0`}=11 and {`q1`,`q0`}≠11, all sampled at the same edge. Remaining in 11 (11→11) is not an entry.
- **Counter update at each edge, in priority order:**
  1. `clr`=1: `cnt` ← 0 and `ovf` ← 0. This applies even if an entry event occurs on the same edge; that entry is lost.
  2. Entry event: `cnt` ← `cnt`+1, computed modulo 2^CNT_W. If `cnt` was all ones, it becomes 0 and `ovf` ← 1.
  3. Otherwise: `cnt` and `ovf` hold.
- `ovf` stays set until `clr` or reset.
- `clr` does not affect the state register or the synchronizer.
- The state register has no legality check: all four codes (00, 01, 10, 11) are stored as given.

## Timing
- **Reset:** `rst_n`=0 forces, immediately and without waiting for a clock edge:
  - `q1`=0, `q0`=0, `z`=0
  - all synchronizer stages = 0, so `x`=0
  - `cnt`=0, `ovf`=0

  Reset asserted mid-operation (including during a pending entry) discards everything. Release takes effect from the first rising edge after `rst_n` goes high.
- **Input latency:** a change on `x_in` that is stable before edge N appears on `x` after edge N+SYNC_STAGES-1. With the default, that is 2 edges.
- **State latency:** `d1`/`d0` captured at edge N appear on `q1`/`q0` just after edge N. Total latency from `x_in` to a state change is therefore SYNC_STAGES+1 edges (3 by default).
- **Output timing:**
  - `z` follows `q` in the same cycle.
  - `cnt` and `ovf` update at the same edge that loads 11 into `q`.
- The feedback loop (`q`/`x` → external next-state generator → `d`) must settle within one clock period. There are no other combinational paths from input to output.

## Test plan
1. **Reset:** hold `rst_n`=0 with `x_in`=1 and `d`=11 for 3 edges → `q`=00, `x`=0, `z`=0, `cnt`=0, `ovf`=0. Release, then toggle `x_in` 0→1 → `x`=1 exactly 2 edges later.
2. **Enable hold:** `en`=1, `d`=10 → `q`=10 after 1 edge. Then set `en`=0 and `d`=01 for 4 edges → `q` stays 10, `cnt` unchanged.
3. **Entry counting:** with `en`=1, drive the state sequence 00→11→11→11→01→11 → `cnt`=2, `z`=1 only while `q`=11.
4. **Wrap (CNT_W=8):** produce 256 entries (alternating `d` 00/11) → `cnt`=0 and `ovf`=1 after the 256th. One more entry → `cnt`=1 with `ovf` still 1.
5. **Clear priority:** assert `clr`=1 on the same edge as a 01→11 entry with `cnt`=5 and `ovf`=1 → `cnt`=0, `ovf`=0, `q`=11.
6. **Reset mid-run:** assert `rst_n`=0 asynchronously between edges while `q`=11 and `cnt`=7 → `q`, `cnt`, `z`, and `x` all go to 0 before the next edge.
